// File: rtl/triangle_rasterizer.sv
// Rasterizes one triangle (IEEE-754 x/y vertices) into framebuffer writes by scanning
// its bounding box one pixel per clock with three integer edge functions.
module triangle_rasterizer #(
    parameter int         SCREEN_W = 640,
    parameter int         SCREEN_H = 480,
    parameter logic [3:0] COLOR    = 4'hF
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        start,
    input  logic [31:0] p1 [3],
    input  logic [31:0] p2 [3],
    input  logic [31:0] p3 [3],
    output logic        done,
    output logic [9:0]  fb_x,
    output logic [9:0]  fb_y,
    output logic [3:0]  data,
    output logic        fb_we
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONVERT = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_SCAN    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [9:0] X_LIM = 10'(SCREEN_W - 1);
    localparam logic [9:0] Y_LIM = 10'(SCREEN_H - 1);

    // Float to unsigned 10-bit, truncating; negatives/small give 0, >=1024/Inf/NaN give 1023.
    function automatic logic [9:0] f2u(input logic [31:0] f);
        logic [7:0]  e;
        logic [23:0] mant;
        logic [4:0]  amt;
        e    = f[30:23];
        mant = {1'b1, f[22:0]};
        if (f[31] || (e < 8'd127)) begin
            f2u = 10'd0;
        end else if (e >= 8'd137) begin
            f2u = 10'd1023;
        end else begin
            amt = 5'(8'd150 - e);
            f2u = 10'(mant >> amt);
        end
    endfunction

    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
        if (v > lim) begin
            clamp10 = lim;
        end else begin
            clamp10 = v;
        end
    endfunction

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m    = (a < b) ? a : b;
        min3 = (m < c) ? m : c;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m    = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

    // E(px,py) = (px-xa)(yb-ya) - (py-ya)(xb-xa); sign tells which side of a->b the point lies.
    function automatic logic signed [23:0] edge_fn(
        input logic [9:0] px, input logic [9:0] py,
        input logic [9:0] xa, input logic [9:0] ya,
        input logic [9:0] xb, input logic [9:0] yb
    );
        logic signed [10:0] t;
        logic signed [21:0] dpx, dpy, dex, dey, pa, pb;
        t   = $signed({1'b0, px}) - $signed({1'b0, xa});
        dpx = {{11{t[10]}}, t};
        t   = $signed({1'b0, py}) - $signed({1'b0, ya});
        dpy = {{11{t[10]}}, t};
        t   = $signed({1'b0, xb}) - $signed({1'b0, xa});
        dex = {{11{t[10]}}, t};
        t   = $signed({1'b0, yb}) - $signed({1'b0, ya});
        dey = {{11{t[10]}}, t};
        pa  = dpx * dey;
        pb  = dpy * dex;
        edge_fn = {{2{pa[21]}}, pa} - {{2{pb[21]}}, pb};
    endfunction

    logic [2:0]  state_r;
    logic [31:0] fx_r [3];
    logic [31:0] fy_r [3];
    logic [9:0]  vx_r [3];
    logic [9:0]  vy_r [3];
    logic [9:0]  xmin_r, xmax_r, ymin_r, ymax_r;
    logic [9:0]  cx_r, cy_r;

    logic signed [23:0] e01_s, e12_s, e20_s, area_s;
    logic               all_ge_s, all_le_s, inside_s;
    logic               unused_z_s;

    assign unused_z_s = ^{p1[2], p2[2], p3[2]};

    // Edge functions at the current scan pixel and the (negated) doubled area for setup.
    always_comb begin
        e01_s    = edge_fn(cx_r, cy_r, vx_r[0], vy_r[0], vx_r[1], vy_r[1]);
        e12_s    = edge_fn(cx_r, cy_r, vx_r[1], vy_r[1], vx_r[2], vy_r[2]);
        e20_s    = edge_fn(cx_r, cy_r, vx_r[2], vy_r[2], vx_r[0], vy_r[0]);
        area_s   = edge_fn(vx_r[2], vy_r[2], vx_r[0], vy_r[0], vx_r[1], vy_r[1]);
        all_ge_s = !e01_s[23] && !e12_s[23] && !e20_s[23];
        all_le_s = (e01_s[23] || (e01_s == 24'sd0)) &&
                   (e12_s[23] || (e12_s == 24'sd0)) &&
                   (e20_s[23] || (e20_s == 24'sd0));
        inside_s = all_ge_s || all_le_s;
    end

    // Control FSM, vertex pipeline, scan counter and registered framebuffer outputs.
    always_ff @(posedge clk) begin
        if (!areset) begin
            state_r <= S_IDLE;
            done    <= 1'b0;
            fb_we   <= 1'b0;
            fb_x    <= 10'd0;
            fb_y    <= 10'd0;
            data    <= 4'h0;
            for (int i = 0; i < 3; i++) begin
                fx_r[i] <= 32'd0;
                fy_r[i] <= 32'd0;
                vx_r[i] <= 10'd0;
                vy_r[i] <= 10'd0;
            end
            xmin_r <= 10'd0;
            xmax_r <= 10'd0;
            ymin_r <= 10'd0;
            ymax_r <= 10'd0;
            cx_r   <= 10'd0;
            cy_r   <= 10'd0;
        end else begin
            done  <= 1'b0;
            fb_we <= 1'b0;
            data  <= 4'h0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        fx_r[0] <= p1[0];
                        fy_r[0] <= p1[1];
                        fx_r[1] <= p2[0];
                        fy_r[1] <= p2[1];
                        fx_r[2] <= p3[0];
                        fy_r[2] <= p3[1];
                        state_r <= S_CONVERT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CONVERT: begin
                    for (int i = 0; i < 3; i++) begin
                        vx_r[i] <= clamp10(f2u(fx_r[i]), X_LIM);
                        vy_r[i] <= clamp10(f2u(fy_r[i]), Y_LIM);
                    end
                    state_r <= S_SETUP;
                end
                S_SETUP: begin
                    xmin_r  <= min3(vx_r[0], vx_r[1], vx_r[2]);
                    xmax_r  <= max3(vx_r[0], vx_r[1], vx_r[2]);
                    ymin_r  <= min3(vy_r[0], vy_r[1], vy_r[2]);
                    ymax_r  <= max3(vy_r[0], vy_r[1], vy_r[2]);
                    cx_r    <= min3(vx_r[0], vx_r[1], vx_r[2]);
                    cy_r    <= min3(vy_r[0], vy_r[1], vy_r[2]);
                    state_r <= (area_s == 24'sd0) ? S_DONE : S_SCAN;
                end
                S_SCAN: begin
                    fb_x  <= cx_r;
                    fb_y  <= cy_r;
                    fb_we <= inside_s;
                    data  <= inside_s ? COLOR : 4'h0;
                    if (cx_r == xmax_r) begin
                        cx_r <= xmin_r;
                        if (cy_r == ymax_r) begin
                            state_r <= S_DONE;
                        end else begin
                            cy_r <= cy_r + 10'd1;
                        end
                    end else begin
                        cx_r <= cx_r + 10'd1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Randomized and directed bench for triangle_rasterizer against a cycle-indexed
// behavioural model of the expected output stream.
module tb_triangle_rasterizer;

    logic        clk = 1'b0;
    logic        areset, start;
    logic [31:0] p1 [3];
    logic [31:0] p2 [3];
    logic [31:0] p3 [3];
    logic        done, fb_we;
    logic [9:0]  fb_x, fb_y;
    logic [3:0]  data;

    always #5 clk = ~clk;

    triangle_rasterizer dut (
        .clk(clk), .areset(areset), .start(start),
        .p1(p1), .p2(p2), .p3(p3),
        .done(done), .fb_x(fb_x), .fb_y(fb_y), .data(data), .fb_we(fb_we)
    );

    typedef struct {
        bit chk_xy;
        bit done;
        bit we;
        int x;
        int y;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;

    localparam logic [31:0] ZVAL = 32'h3F800000;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference float -> pixel conversion from the value itself.
    function automatic int conv(input logic [31:0] f, input int lim);
        int  e, r;
        real v;
        e = int'(f[30:23]);
        if (f[31]) r = 0;
        else if (e == 255) r = 1023;
        else if (e < 127) r = 0;
        else begin
            v = 1.0 + real'(int'(f[22:0])) / 8388608.0;
            for (int k = 127; k < e; k++) v = v * 2.0;
            r = (v >= 1024.0) ? 1023 : $rtoi(v);
        end
        if (r > lim) r = lim;
        return r;
    endfunction

    // Encode q/4 (q >= 0) as a single-precision float.
    function automatic logic [31:0] enc(input int q);
        int          p;
        logic [31:0] m;
        if (q == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 31; i++) if (q[i]) p = i;
        m = 32'(q) << (23 - p);
        return {1'b0, 8'(125 + p), m[22:0]};
    endfunction

    function automatic int side(input int px, input int py, input int xa, input int ya, input int xb, input int yb);
        return (px - xa) * (yb - ya) - (py - ya) * (xb - xa);
    endfunction

    // Per-cycle comparison of DUT outputs against the model stream.
    always @(posedge clk) begin
        exp_t        e;
        logic [25:0] act, req, mask;
        #1;
        act  = {done, fb_we, data, fb_x, fb_y};
        mask = {6'h3F, 20'h0};
        req  = 26'd0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            req = {e.done, e.we, (e.we ? 4'hF : 4'h0), 10'(e.x), 10'(e.y)};
            if (e.chk_xy) mask = {26{1'b1}};
        end
        check(((act ^ req) & mask) == 26'd0, "cycle", 64'(act), 64'(req));
        check((fb_x <= 10'd639) && (fb_y <= 10'd479), "range", 64'({fb_x, fb_y}), 64'({10'd639, 10'd479}));
        if (fb_we === 1'b1) wr_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic launch(input logic [31:0] ax, input logic [31:0] ay, input logic [31:0] bx,
                          input logic [31:0] by, input logic [31:0] cx, input logic [31:0] cy,
                          output int npix, output int nwr);
        int x[3], y[3];
        int a, xl, xh, yl, yh, e0, e1, e2;
        bit in;
        @(negedge clk);
        p1[0] = ax; p1[1] = ay; p1[2] = ZVAL;
        p2[0] = bx; p2[1] = by; p2[2] = ZVAL;
        p3[0] = cx; p3[1] = cy; p3[2] = ZVAL;
        start = 1'b1;
        x[0] = conv(ax, 639); y[0] = conv(ay, 479);
        x[1] = conv(bx, 639); y[1] = conv(by, 479);
        x[2] = conv(cx, 639); y[2] = conv(cy, 479);
        a  = (x[1] - x[0]) * (y[2] - y[0]) - (y[1] - y[0]) * (x[2] - x[0]);
        xl = x[0]; xh = x[0]; yl = y[0]; yh = y[0];
        for (int i = 1; i < 3; i++) begin
            if (x[i] < xl) xl = x[i];
            if (x[i] > xh) xh = x[i];
            if (y[i] < yl) yl = y[i];
            if (y[i] > yh) yh = y[i];
        end
        repeat (3) exp_q.push_back('{1'b0, 1'b0, 1'b0, 0, 0});
        npix = 0;
        nwr  = 0;
        if (a != 0) begin
            for (int yy = yl; yy <= yh; yy++) begin
                for (int xx = xl; xx <= xh; xx++) begin
                    e0 = side(xx, yy, x[0], y[0], x[1], y[1]);
                    e1 = side(xx, yy, x[1], y[1], x[2], y[2]);
                    e2 = side(xx, yy, x[2], y[2], x[0], y[0]);
                    in = (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
                    exp_q.push_back('{1'b1, 1'b0, in, xx, yy});
                    npix++;
                    if (in) nwr++;
                end
            end
        end
        exp_q.push_back('{1'b0, 1'b1, 1'b0, 0, 0});
        wr_cnt   = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(exp_q.size() == 0, "timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic run(input string name, input logic [31:0] ax, input logic [31:0] ay, input logic [31:0] bx,
                       input logic [31:0] by, input logic [31:0] cx, input logic [31:0] cy,
                       output int npix, output int nwr);
        launch(ax, ay, bx, by, cx, cy, npix, nwr);
        wait_done(npix + 20);
        check(wr_cnt == nwr, {name, "_writes"}, 64'(wr_cnt), 64'(nwr));
        check(done_cnt == 1, {name, "_done"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int np, nw;
        logic [31:0] v [6];
        areset = 1'b0;
        start  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p1[i] = 32'd0; p2[i] = 32'd0; p3[i] = 32'd0;
        end
        repeat (3) exp_q.push_back('{1'b1, 1'b0, 1'b0, 0, 0});
        repeat (3) @(negedge clk);
        areset = 1'b1;
        start  = 1'b0;

        check(conv(32'h428A0000, 639) == 69, "conv69", 64'(conv(32'h428A0000, 639)), 64'd69);
        check(conv(32'h43290000, 639) == 169, "conv169", 64'(conv(32'h43290000, 639)), 64'd169);
        check(conv(32'hC0A00000, 639) == 0, "conv_neg", 64'(conv(32'hC0A00000, 639)), 64'd0);
        check(conv(32'h44FA0000, 479) == 479, "conv_clampy", 64'(conv(32'h44FA0000, 479)), 64'd479);
        check(conv(enc(279), 639) == 69, "conv_frac", 64'(conv(enc(279), 639)), 64'd69);
        check(enc(276) == 32'h428A0000, "enc69", 64'(enc(276)), 64'h428A0000);

        run("right", 32'h428A0000, 32'h428A0000, 32'h43290000, 32'h428A0000, 32'h428A0000, 32'h43290000, np, nw);
        check(np == 10201, "right_pix", 64'(np), 64'd10201);
        check(nw == 5151, "right_wr", 64'(nw), 64'd5151);

        run("winding", 32'h428A0000, 32'h428A0000, 32'h428A0000, 32'h43290000, 32'h43290000, 32'h428A0000, np, nw);
        check(nw == 5151, "winding_wr", 64'(nw), 64'd5151);

        run("clamp", 32'h428A0000, 32'h428A0000, 32'hC0A00000, 32'h428A0000, 32'h428A0000, 32'h44FA0000, np, nw);
        check(np == 70 * 411, "clamp_pix", 64'(np), 64'd28770);

        run("degen", enc(40), enc(40), enc(80), enc(80), enc(120), enc(120), np, nw);
        check(np == 0, "degen_pix", 64'(np), 64'd0);

        run("point", enc(20), enc(20), enc(20), enc(20), enc(20), enc(20), np, nw);

        for (int t = 0; t < 6; t++) begin
            int bx0, by0;
            bx0 = int'($urandom_range(0, 600));
            by0 = int'($urandom_range(0, 440));
            for (int i = 0; i < 6; i++) begin
                v[i] = enc(4 * (((i % 2) == 0 ? bx0 : by0) + int'($urandom_range(0, 30))) + int'($urandom_range(0, 3)));
                if ($urandom_range(0, 9) == 0) v[i] = v[i] | 32'h80000000;
            end
            run("random", v[0], v[1], v[2], v[3], v[4], v[5], np, nw);
        end

        launch(32'h428A0000, 32'h428A0000, 32'h43290000, 32'h428A0000, 32'h428A0000, 32'h43290000, np, nw);
        repeat (40) @(negedge clk);
        areset = 1'b0;
        exp_q.delete();
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 0, 0});
        @(negedge clk);
        areset = 1'b1;
        repeat (3) @(negedge clk);
        check(done_cnt == 0, "abort_done", 64'(done_cnt), 64'd0);
        run("after_reset", enc(40), enc(48), enc(120), enc(60), enc(72), enc(140), np, nw);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
